uart_param_core: RTL and testbench

Parametrised full-duplex UART transceiver: one single-clock block carrying both receive and transmit, with configurable data width, parity, stop bits and oversampling. It replaces the receive-only top level and its derived-clock baud timer. All logic runs on PCLK, and baud timing uses clock-enable ticks, not generated clocks. It sits between a pad-level rx/tx pair and the MCU-side byte interface.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_param_core_if.sv | 25 ++
 rtl/uart_baud_tick.sv | 26 ++
 rtl/uart_param_core.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_param_core.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and divider helper for the UART core.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

  // Clock cycles per oversample tick, floored, never below 1.
  function automatic int unsigned calc_div(int unsigned clock, int unsigned baud,
                                           int unsigned os);
    int unsigned d;
    d = clock / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_param_core_if.sv
// Pad-side serial pair plus MCU-side byte interface of the UART core.
interface uart_param_core_if #(
  parameter int unsigned DBITS = 8
);
  logic             rx;
  logic             tx;
  logic             tx_start;
  logic [DBITS-1:0] tx_din;
  logic             tx_busy;
  logic             tx_done;
  logic [DBITS-1:0] rx_dout;
  logic             rx_done;
  logic             rx_parity_err;
  logic             rx_frame_err;

  modport slave (
    input  rx, tx_start, tx_din,
    output tx, tx_busy, tx_done, rx_dout, rx_done, rx_parity_err, rx_frame_err
  );

  modport master (
    output rx, tx_start, tx_din,
    input  tx, tx_busy, tx_done, rx_dout, rx_done, rx_parity_err, rx_frame_err
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle oversample tick enable.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);
  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Wrap at DIV-1 so the tick fires once every DIV cycles.
  always_comb begin
    cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == CntLast);
endmodule

// File: rtl/uart_param_core.sv
// Full-duplex UART: oversampled receiver and bit-timed transmitter on one clock.
module uart_param_core
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 100000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DBITS      = 8,
  parameter int unsigned PARITY     = PAR_NONE,
  parameter int unsigned STOP_BITS  = 1
) (
  input logic              PCLK,
  input logic              PRESETn,
  uart_param_core_if.slave bus
);
  localparam int unsigned Div       = calc_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned BitCycles = Div * OVERSAMPLE;
  localparam int unsigned SW        = $clog2(OVERSAMPLE);
  localparam int unsigned TW        = (BitCycles > 1) ? $clog2(BitCycles) : 1;
  localparam int unsigned NW        = $clog2(DBITS);
  localparam logic [SW-1:0] SMid    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SLast   = SW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TLast   = TW'(BitCycles - 1);
  localparam logic [NW-1:0] NLast   = NW'(DBITS - 1);
  localparam logic HasPar   = (PARITY != PAR_NONE);
  localparam logic IsOdd    = (PARITY == PAR_ODD);
  localparam logic StopLast = (STOP_BITS == 2);

  logic tick;
  uart_baud_tick #(.DIV(Div)) u_tick (.clk_i(PCLK), .rst_ni(PRESETn), .tick_o(tick));

  // ---------------- receiver ----------------
  logic [1:0]       sync_q;
  logic             rx_s;
  uart_state_t      rx_st_q, rx_st_d;
  logic [SW-1:0]    rx_s_q, rx_s_d;
  logic [NW-1:0]    rx_n_q, rx_n_d;
  logic [DBITS-1:0] rx_sh_q, rx_sh_d, rx_dout_q, rx_dout_d;
  logic rx_par_q, rx_par_d, armed_q, armed_d;
  logic rx_pe_q, rx_pe_d, rx_fe_q, rx_fe_d, rx_done_q, rx_done_d;

  // Two-flop synchroniser, idles high so reset never looks like a start bit.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], bus.rx};
  end
  assign rx_s = sync_q[1];

  // Rx next state: mid-bit sampling on oversample ticks; a frame error disarms until line high.
  always_comb begin
    rx_st_d   = rx_st_q;
    rx_s_d    = rx_s_q;
    rx_n_d    = rx_n_q;
    rx_sh_d   = rx_sh_q;
    rx_par_d  = rx_par_q;
    rx_dout_d = rx_dout_q;
    rx_pe_d   = rx_pe_q;
    rx_fe_d   = rx_fe_q;
    rx_done_d = 1'b0;
    armed_d   = armed_q | (tick & rx_s);
    case (rx_st_q)
      IDLE: if (!rx_s && armed_q) begin
        rx_st_d = START;
        rx_s_d  = '0;
      end
      START: if (tick) begin
        if (rx_s_q == SMid) begin
          rx_s_d  = '0;
          rx_n_d  = '0;
          rx_st_d = rx_s ? IDLE : DATA;
        end else begin
          rx_s_d = rx_s_q + 1'b1;
        end
      end
      DATA: if (tick) begin
        if (rx_s_q == SLast) begin
          rx_s_d  = '0;
          rx_sh_d = {rx_s, rx_sh_q[DBITS-1:1]};
          rx_n_d  = rx_n_q + 1'b1;
          if (rx_n_q == NLast) begin
            if (HasPar) rx_st_d = uart_pkg::PARITY;
            else        rx_st_d = STOP;
          end
        end else begin
          rx_s_d = rx_s_q + 1'b1;
        end
      end
      uart_pkg::PARITY: if (tick) begin
        if (rx_s_q == SLast) begin
          rx_s_d   = '0;
          rx_par_d = rx_s;
          rx_st_d  = STOP;
        end else begin
          rx_s_d = rx_s_q + 1'b1;
        end
      end
      STOP: if (tick) begin
        if (rx_s_q == SLast) begin
          rx_s_d    = '0;
          rx_dout_d = rx_sh_q;
          rx_fe_d   = !rx_s;
          rx_pe_d   = HasPar & ((^rx_sh_q) ^ rx_par_q ^ IsOdd);
          rx_done_d = 1'b1;
          if (!rx_s) armed_d = 1'b0;
          rx_st_d   = IDLE;
        end else begin
          rx_s_d = rx_s_q + 1'b1;
        end
      end
      default: rx_st_d = IDLE;
    endcase
  end

  // Rx state register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_st_q   <= IDLE;
      rx_s_q    <= '0;
      rx_n_q    <= '0;
      rx_sh_q   <= '0;
      rx_par_q  <= 1'b0;
      rx_dout_q <= '0;
      rx_pe_q   <= 1'b0;
      rx_fe_q   <= 1'b0;
      rx_done_q <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      rx_st_q   <= rx_st_d;
      rx_s_q    <= rx_s_d;
      rx_n_q    <= rx_n_d;
      rx_sh_q   <= rx_sh_d;
      rx_par_q  <= rx_par_d;
      rx_dout_q <= rx_dout_d;
      rx_pe_q   <= rx_pe_d;
      rx_fe_q   <= rx_fe_d;
      rx_done_q <= rx_done_d;
      armed_q   <= armed_d;
    end
  end

  // ---------------- transmitter ----------------
  uart_state_t      tx_st_q, tx_st_d;
  logic [TW-1:0]    tx_cnt_q, tx_cnt_d;
  logic [NW-1:0]    tx_n_q, tx_n_d;
  logic [DBITS-1:0] tx_sh_q, tx_sh_d;
  logic tx_par_q, tx_par_d, tx_stop_q, tx_stop_d;
  logic tx_q, tx_d, busy_q, busy_d, done_q, done_d, bit_end;

  // Tx next state: each bit held for BitCycles; busy is low exactly when IDLE.
  always_comb begin
    tx_st_d   = tx_st_q;
    tx_cnt_d  = tx_cnt_q;
    tx_n_d    = tx_n_q;
    tx_sh_d   = tx_sh_q;
    tx_par_d  = tx_par_q;
    tx_stop_d = tx_stop_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bit_end   = (tx_cnt_q == TLast);
    if (tx_st_q != IDLE) tx_cnt_d = bit_end ? '0 : tx_cnt_q + 1'b1;
    case (tx_st_q)
      IDLE: if (bus.tx_start) begin
        tx_st_d   = START;
        tx_cnt_d  = '0;
        tx_sh_d   = bus.tx_din;
        tx_par_d  = (^bus.tx_din) ^ IsOdd;
        tx_stop_d = 1'b0;
        tx_d      = 1'b0;
        busy_d    = 1'b1;
      end
      START: if (bit_end) begin
        tx_st_d = DATA;
        tx_n_d  = '0;
        tx_d    = tx_sh_q[0];
        tx_sh_d = tx_sh_q >> 1;
      end
      DATA: if (bit_end) begin
        if (tx_n_q == NLast) begin
          if (HasPar) begin
            tx_st_d = uart_pkg::PARITY;
            tx_d    = tx_par_q;
          end else begin
            tx_st_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          tx_n_d  = tx_n_q + 1'b1;
          tx_d    = tx_sh_q[0];
          tx_sh_d = tx_sh_q >> 1;
        end
      end
      uart_pkg::PARITY: if (bit_end) begin
        tx_st_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: if (bit_end) begin
        if (tx_stop_q == StopLast) begin
          tx_st_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          tx_stop_d = 1'b1;
        end
      end
      default: tx_st_d = IDLE;
    endcase
  end

  // Tx state register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_st_q   <= IDLE;
      tx_cnt_q  <= '0;
      tx_n_q    <= '0;
      tx_sh_q   <= '0;
      tx_par_q  <= 1'b0;
      tx_stop_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_n_q    <= tx_n_d;
      tx_sh_q   <= tx_sh_d;
      tx_par_q  <= tx_par_d;
      tx_stop_q <= tx_stop_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.tx            = tx_q;
  assign bus.tx_busy       = busy_q;
  assign bus.tx_done       = done_q;
  assign bus.rx_dout       = rx_dout_q;
  assign bus.rx_done       = rx_done_q;
  assign bus.rx_parity_err = rx_pe_q;
  assign bus.rx_frame_err  = rx_fe_q;
endmodule

// File: tb/tb_uart_param_core.sv
// Bench for uart_param_core: 8N1 instance for tx timing, 8E1 instance for rx/loopback.
module tb_uart_param_core;
  localparam int unsigned Bit = 160;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rx_exp_t;

  typedef struct {
    logic [7:0] d;
    logic       pbit;
    logic       sbit;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tb_rx = 1'b1;
  logic lb_sel = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   rx_cnt_e = 0;
  int   tx_cnt_e = 0;
  rx_exp_t exp_q[$];
  rx_exp_t mon_e;
  vec_t vecs[6];

  always #5 clk = ~clk;

  uart_param_core_if #(.DBITS(8)) bus_n ();
  uart_param_core_if #(.DBITS(8)) bus_e ();

  assign bus_n.rx = bus_n.tx;
  assign bus_e.rx = lb_sel ? bus_e.tx : tb_rx;

  uart_param_core #(
    .CLOCK_RATE(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16),
    .DBITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_n (.PCLK(clk), .PRESETn(rst_n), .bus(bus_n));

  uart_param_core #(
    .CLOCK_RATE(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16),
    .DBITS(8), .PARITY(1), .STOP_BITS(1)
  ) u_e (.PCLK(clk), .PRESETn(rst_n), .bus(bus_e));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every rx_done of the 8E1 instance pops one expected record.
  always @(negedge clk) begin
    if (bus_e.rx_done) begin
      rx_cnt_e++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected: got rx_done with dout 0x%0h, expected none", bus_e.rx_dout);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rx_dout", {24'h0, bus_e.rx_dout}, {24'h0, mon_e.d});
        chk("rx_parity_err", {31'h0, bus_e.rx_parity_err}, {31'h0, mon_e.pe});
        chk("rx_frame_err", {31'h0, bus_e.rx_frame_err}, {31'h0, mon_e.fe});
      end
    end
    if (bus_e.tx_done) tx_cnt_e++;
  end

  // Bit-bangs one 8E1 frame onto the 8E1 receiver, then idles two bit times.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    tb_rx = 1'b0;
    repeat (Bit) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tb_rx = d[i];
      repeat (Bit) @(negedge clk);
    end
    tb_rx = p;
    repeat (Bit) @(negedge clk);
    tb_rx = s;
    repeat (Bit) @(negedge clk);
    tb_rx = 1'b1;
    repeat (2 * Bit) @(negedge clk);
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [9:0] exp_bits;
    logic       found;
    int         errs;
    int         c_rx;
    int         c_tx;

    vecs[0] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[5] = '{8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};

    bus_n.tx_start = 1'b0;
    bus_n.tx_din   = 8'h00;
    bus_e.tx_start = 1'b0;
    bus_e.tx_din   = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'h0, bus_e.tx}, 32'h1);
    chk("rst_tx_busy", {31'h0, bus_e.tx_busy}, 32'h0);
    chk("rst_tx_done", {31'h0, bus_e.tx_done}, 32'h0);
    chk("rst_rx_done", {31'h0, bus_e.rx_done}, 32'h0);
    chk("rst_rx_dout", {24'h0, bus_e.rx_dout}, 32'h0);
    chk("rst_rx_perr", {31'h0, bus_e.rx_parity_err}, 32'h0);
    chk("rst_rx_ferr", {31'h0, bus_e.rx_frame_err}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // TX 8N1 0xA5: exact bit widths, done at 1600 cycles, re-accept in done cycle.
    bus_n.tx_din   = 8'hA5;
    bus_n.tx_start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!bus_n.tx) begin
        found = 1'b1;
        break;
      end
    end
    chk("tx_start_low", {31'h0, found}, 32'h1);
    exp_bits = {1'b1, bus_n.tx_din, 1'b0};
    for (int k = 0; k < 10; k++) begin
      errs = 0;
      for (int j = 0; j < Bit; j++) begin
        if (k != 0 || j != 0) @(negedge clk);
        if (bus_n.tx !== exp_bits[k] || bus_n.tx_busy !== 1'b1 || bus_n.tx_done !== 1'b0)
          errs++;
      end
      chk($sformatf("tx_bit%0d_bad_samples", k), errs, 0);
    end
    @(negedge clk);
    chk("tx_done_at_1600", {31'h0, bus_n.tx_done}, 32'h1);
    chk("tx_busy_drop", {31'h0, bus_n.tx_busy}, 32'h0);
    chk("tx_idle_high", {31'h0, bus_n.tx}, 32'h1);
    @(negedge clk);
    bus_n.tx_start = 1'b0;
    chk("tx_reaccept_low", {31'h0, bus_n.tx}, 32'h0);
    chk("tx_reaccept_busy", {31'h0, bus_n.tx_busy}, 32'h1);
    chk("tx_reaccept_done", {31'h0, bus_n.tx_done}, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus_n.tx_done) begin
        found = 1'b1;
        break;
      end
    end
    chk("tx_second_done", {31'h0, found}, 32'h1);

    // Loopback 8E1 0x3C.
    lb_sel = 1'b1;
    c_rx = rx_cnt_e;
    c_tx = tx_cnt_e;
    exp_q.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0});
    bus_e.tx_din   = 8'h3C;
    bus_e.tx_start = 1'b1;
    @(negedge clk);
    bus_e.tx_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2200; i++) begin
      @(negedge clk);
      if (tx_cnt_e != c_tx) begin
        found = 1'b1;
        break;
      end
    end
    chk("lb_tx_done", {31'h0, found}, 32'h1);
    repeat (20) @(negedge clk);
    chk("lb_rx_done_count", rx_cnt_e - c_rx, 1);
    lb_sel = 1'b0;
    repeat (Bit) @(negedge clk);

    // Injected frames from the vector table.
    for (int v = 0; v < 6; v++) begin
      exp_q.push_back('{d: vecs[v].exp_d, pe: vecs[v].exp_pe, fe: vecs[v].exp_fe});
      send_frame(vecs[v].d, vecs[v].pbit, vecs[v].sbit);
    end
    chk("vec_queue_drained", exp_q.size(), 0);

    // Break: 20 bit times low yields exactly one frame-error word.
    c_rx = rx_cnt_e;
    exp_q.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
    tb_rx = 1'b0;
    repeat (20 * Bit) @(negedge clk);
    chk("break_one_done", rx_cnt_e - c_rx, 1);
    tb_rx = 1'b1;
    repeat (2 * Bit) @(negedge clk);
    exp_q.push_back('{d: 8'h55, pe: 1'b0, fe: 1'b0});
    send_frame(8'h55, 1'b0, 1'b1);
    chk("break_recover_count", rx_cnt_e - c_rx, 2);

    // Glitch shorter than half a bit, then a clean frame proves return to IDLE.
    c_rx = rx_cnt_e;
    tb_rx = 1'b0;
    repeat (40) @(negedge clk);
    tb_rx = 1'b1;
    repeat (3 * Bit) @(negedge clk);
    chk("glitch_no_done", rx_cnt_e - c_rx, 0);
    exp_q.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b0});
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("glitch_then_frame", rx_cnt_e - c_rx, 1);

    // Reset during tx data bit 3 (and rx DATA via loopback).
    lb_sel = 1'b1;
    c_rx = rx_cnt_e;
    c_tx = tx_cnt_e;
    bus_e.tx_din   = 8'h96;
    bus_e.tx_start = 1'b1;
    @(negedge clk);
    bus_e.tx_start = 1'b0;
    repeat (4 * Bit + Bit / 2) @(negedge clk);
    chk("pre_rst_busy", {31'h0, bus_e.tx_busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", {31'h0, bus_e.tx}, 32'h1);
    chk("mid_rst_busy", {31'h0, bus_e.tx_busy}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * Bit) @(negedge clk);
    chk("mid_rst_no_rx_done", rx_cnt_e - c_rx, 0);
    chk("mid_rst_no_tx_done", tx_cnt_e - c_tx, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
